// File: rtl/dec_fwd_regfile.sv
// Decode-stage operand unit: register file with E/M/W forwarding, write-through,
// load-use / RAW interlock detection and stall statistics.
module dec_fwd_regfile #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned NRP     = 2,
  parameter bit          FWD_EN  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid_d,
  input  logic [NRP-1:0]      i_re,
  input  logic [NRP*AW-1:0]   i_ra,
  input  logic                i_we_e,
  input  logic [AW-1:0]       i_wa_e,
  input  logic                i_isload_e,
  input  logic [XLEN-1:0]     i_aluout_e,
  input  logic                i_we_m,
  input  logic [AW-1:0]       i_wa_m,
  input  logic                i_isload_m,
  input  logic [XLEN-1:0]     i_aluout_m,
  input  logic [XLEN-1:0]     i_dmem_rdata_m,
  input  logic                i_we_w,
  input  logic [AW-1:0]       i_wa_w,
  input  logic [XLEN-1:0]     i_wdata_w,
  output logic [NRP*XLEN-1:0] o_rd,
  output logic                o_stall,
  output logic                o_flush_e,
  output logic [1:0]          o_stall_cause,
  output logic [15:0]         o_stall_cnt
);

  localparam int unsigned CNT_W = 16;

  logic [XLEN-1:0]  r_regs [NREG];
  logic [1:0]       r_stall_cause;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_wr_en;
  logic [NRP-1:0]   w_hz_lu;
  logic [NRP-1:0]   w_hz_raw;
  logic             w_any_lu;
  logic             w_any_raw;
  logic             w_stall;

  assign w_wr_en = i_we_w
                 && !(ZERO_R0 && (i_wa_w == '0))
                 && (32'(i_wa_w) < NREG);

  // Architectural register file, written from the W stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa_w] <= i_wdata_w;
    end
  end

  // Per read port: forwarding mux (youngest producer wins) and hazard detection.
  for (genvar k = 0; k < NRP; k++) begin : g_port
    logic [AW-1:0]   w_addr;
    logic            w_zero;
    logic            w_in_range;
    logic            w_match_e;
    logic            w_match_m;
    logic            w_match_w;
    logic [XLEN-1:0] w_data;

    assign w_addr     = i_ra[k*AW +: AW];
    assign w_zero     = ZERO_R0 && (w_addr == '0);
    assign w_in_range = (32'(w_addr) < NREG);
    assign w_match_e  = i_we_e && (i_wa_e == w_addr);
    assign w_match_m  = i_we_m && (i_wa_m == w_addr);
    assign w_match_w  = i_we_w && (i_wa_w == w_addr);

    always_comb begin
      w_data = '0;
      if (w_zero) begin
        w_data = '0;
      end else if (FWD_EN && w_match_e && !i_isload_e) begin
        w_data = i_aluout_e;
      end else if (FWD_EN && w_match_m) begin
        w_data = i_isload_m ? i_dmem_rdata_m : i_aluout_m;
      end else if (w_match_w) begin
        w_data = i_wdata_w;
      end else if (w_in_range) begin
        w_data = r_regs[w_addr];
      end
    end

    assign o_rd[k*XLEN +: XLEN] = w_data;

    // With forwarding only a load in E cannot be bypassed; without it any E/M producer blocks.
    assign w_hz_lu[k]  = FWD_EN && i_re[k] && !w_zero && w_match_e && i_isload_e;
    assign w_hz_raw[k] = !FWD_EN && i_re[k] && !w_zero && (w_match_e || w_match_m);
  end

  assign w_any_lu  = |w_hz_lu;
  assign w_any_raw = |w_hz_raw;
  assign w_stall   = !rst && i_valid_d && (w_any_lu || w_any_raw);

  assign o_stall   = w_stall;
  assign o_flush_e = w_stall;

  // Stall cause (one-cycle lag) and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cause <= 2'd0;
      r_stall_cnt   <= '0;
    end else begin
      if (!w_stall) begin
        r_stall_cause <= 2'd0;
      end else if (w_any_lu) begin
        r_stall_cause <= 2'd1;
      end else begin
        r_stall_cause <= 2'd2;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cause = r_stall_cause;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_dec_fwd_regfile.sv
// Directed bench: one forwarding instance and one interlock-only instance share
// stimulus; each step checks outputs against hand-computed values.
module tb_dec_fwd_regfile;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRP  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_valid_d;
  logic [NRP-1:0]      i_re;
  logic [NRP*AW-1:0]   i_ra;
  logic                i_we_e, i_isload_e, i_we_m, i_isload_m, i_we_w;
  logic [AW-1:0]       i_wa_e, i_wa_m, i_wa_w;
  logic [XLEN-1:0]     i_aluout_e, i_aluout_m, i_dmem_rdata_m, i_wdata_w;

  logic [NRP*XLEN-1:0] rd_f, rd_n;
  logic                stall_f, stall_n, flush_f, flush_n;
  logic [1:0]          cause_f, cause_n;
  logic [15:0]         cnt_f, cnt_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_fwd_regfile #(.XLEN(XLEN), .NREG(32), .NRP(NRP), .FWD_EN(1'b1), .ZERO_R0(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .i_valid_d(i_valid_d), .i_re(i_re), .i_ra(i_ra),
    .i_we_e(i_we_e), .i_wa_e(i_wa_e), .i_isload_e(i_isload_e), .i_aluout_e(i_aluout_e),
    .i_we_m(i_we_m), .i_wa_m(i_wa_m), .i_isload_m(i_isload_m), .i_aluout_m(i_aluout_m),
    .i_dmem_rdata_m(i_dmem_rdata_m), .i_we_w(i_we_w), .i_wa_w(i_wa_w), .i_wdata_w(i_wdata_w),
    .o_rd(rd_f), .o_stall(stall_f), .o_flush_e(flush_f), .o_stall_cause(cause_f),
    .o_stall_cnt(cnt_f)
  );

  dec_fwd_regfile #(.XLEN(XLEN), .NREG(32), .NRP(NRP), .FWD_EN(1'b0), .ZERO_R0(1'b1)) u_nof (
    .clk(clk), .rst(rst), .i_valid_d(i_valid_d), .i_re(i_re), .i_ra(i_ra),
    .i_we_e(i_we_e), .i_wa_e(i_wa_e), .i_isload_e(i_isload_e), .i_aluout_e(i_aluout_e),
    .i_we_m(i_we_m), .i_wa_m(i_wa_m), .i_isload_m(i_isload_m), .i_aluout_m(i_aluout_m),
    .i_dmem_rdata_m(i_dmem_rdata_m), .i_we_w(i_we_w), .i_wa_w(i_wa_w), .i_wdata_w(i_wdata_w),
    .o_rd(rd_n), .o_stall(stall_n), .o_flush_e(flush_n), .o_stall_cause(cause_n),
    .o_stall_cnt(cnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_valid_d = 1'b0; i_re = '0; i_ra = '0;
    i_we_e = 1'b0; i_wa_e = '0; i_isload_e = 1'b0; i_aluout_e = '0;
    i_we_m = 1'b0; i_wa_m = '0; i_isload_m = 1'b0; i_aluout_m = '0; i_dmem_rdata_m = '0;
    i_we_w = 1'b0; i_wa_w = '0; i_wdata_w = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    i_ra = {a1, a0};
  endtask

  initial begin
    // Reset: outputs cleared, stall suppressed even with a load-use pattern present
    rst = 1'b1;
    idle();
    set_ra(5'd0, 5'd5);
    i_we_e = 1'b1; i_wa_e = 5'd5; i_isload_e = 1'b1; i_valid_d = 1'b1; i_re = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rd_r5", rd_f[31:0], 32'h0);
    chk("rst_stall", {31'd0, stall_f}, 32'd0);
    chk("rst_flush", {31'd0, flush_f}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_f}, 32'd0);
    chk("rst_cause", {30'd0, cause_f}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    idle();
    i_we_w = 1'b1; i_wa_w = 5'd5; i_wdata_w = 32'h0000_A5A5;
    @(posedge clk);
    @(negedge clk);
    idle();
    set_ra(5'd0, 5'd5);
    #1;
    chk("reg_r5", rd_f[31:0], 32'h0000_A5A5);

    // Write-through on port 1, and r0 hard-wired to zero
    @(negedge clk);
    idle();
    set_ra(5'd7, 5'd0);
    i_we_w = 1'b1; i_wa_w = 5'd7; i_wdata_w = 32'h0000_1234;
    #1;
    chk("wt_r7_p1", rd_f[63:32], 32'h0000_1234);
    @(negedge clk);
    i_wa_w = 5'd0; i_wdata_w = 32'h0000_FFFF;
    set_ra(5'd7, 5'd0);
    #1;
    chk("wt_r0", rd_f[31:0], 32'h0);
    chk("reg_r7_p1", rd_f[63:32], 32'h0000_1234);
    @(negedge clk);
    idle();
    #1;
    chk("r0_after_write", rd_f[31:0], 32'h0);

    // Forward priority E > M > W; no-forward instance only sees write-through
    @(negedge clk);
    idle();
    set_ra(5'd0, 5'd3);
    i_we_e = 1'b1; i_wa_e = 5'd3; i_aluout_e = 32'h11;
    i_we_m = 1'b1; i_wa_m = 5'd3; i_aluout_m = 32'h22; i_dmem_rdata_m = 32'h44;
    i_we_w = 1'b1; i_wa_w = 5'd3; i_wdata_w = 32'h33;
    #1;
    chk("fwd_e", rd_f[31:0], 32'h11);
    chk("nof_w", rd_n[31:0], 32'h33);
    i_we_e = 1'b0;
    #1;
    chk("fwd_m_alu", rd_f[31:0], 32'h22);
    i_isload_m = 1'b1;
    #1;
    chk("fwd_m_load", rd_f[31:0], 32'h44);
    i_we_e = 1'b1; i_isload_e = 1'b1;
    i_valid_d = 1'b0;
    #1;
    chk("fwd_e_load_skips", rd_f[31:0], 32'h44);

    // Load-use stall
    @(negedge clk);
    idle();
    set_ra(5'd0, 5'd4);
    i_we_e = 1'b1; i_wa_e = 5'd4; i_isload_e = 1'b1; i_valid_d = 1'b1; i_re = 2'b01;
    #1;
    chk("lu_stall", {31'd0, stall_f}, 32'd1);
    chk("lu_flush", {31'd0, flush_f}, 32'd1);
    @(posedge clk); #1;
    chk("lu_cause", {30'd0, cause_f}, 32'd1);
    chk("lu_cnt", {16'd0, cnt_f}, 32'd1);
    chk("nof_e_cause", {30'd0, cause_n}, 32'd2);
    chk("nof_e_cnt", {16'd0, cnt_n}, 32'd1);
    @(negedge clk);
    i_valid_d = 1'b0;
    #1;
    chk("inv_stall", {31'd0, stall_f}, 32'd0);
    @(posedge clk); #1;
    chk("inv_cnt", {16'd0, cnt_f}, 32'd1);
    chk("inv_cause", {30'd0, cause_f}, 32'd0);

    // Disabled port never stalls
    @(negedge clk);
    i_valid_d = 1'b1; i_re = 2'b10;
    #1;
    chk("re_off_stall", {31'd0, stall_f}, 32'd0);

    // Interlock-only instance on an M producer
    @(negedge clk);
    idle();
    i_we_w = 1'b1; i_wa_w = 5'd9; i_wdata_w = 32'h99;
    @(posedge clk);
    @(negedge clk);
    idle();
    set_ra(5'd0, 5'd9);
    i_we_m = 1'b1; i_wa_m = 5'd9; i_aluout_m = 32'hDEAD; i_valid_d = 1'b1; i_re = 2'b01;
    #1;
    chk("raw_stall_n", {31'd0, stall_n}, 32'd1);
    chk("raw_rd_n", rd_n[31:0], 32'h99);
    chk("raw_stall_f", {31'd0, stall_f}, 32'd0);
    chk("raw_rd_f", rd_f[31:0], 32'hDEAD);
    @(posedge clk); #1;
    chk("raw_cause_n", {30'd0, cause_n}, 32'd2);
    chk("raw_cnt_n", {16'd0, cnt_n}, 32'd2);
    chk("raw_cnt_f", {16'd0, cnt_f}, 32'd1);
    @(negedge clk);
    set_ra(5'd9, 5'd0); i_re = 2'b10;
    #1;
    chk("raw_p1_stall_n", {31'd0, stall_n}, 32'd1);

    // Saturation then asynchronous reset mid-stall
    @(negedge clk);
    idle();
    set_ra(5'd5, 5'd4);
    i_we_e = 1'b1; i_wa_e = 5'd4; i_isload_e = 1'b1; i_valid_d = 1'b1; i_re = 2'b01;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt_f", {16'd0, cnt_f}, 32'h0000_FFFF);
    chk("sat_cnt_n", {16'd0, cnt_n}, 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("sat_hold_f", {16'd0, cnt_f}, 32'h0000_FFFF);
    @(negedge clk); #1;
    chk("pre_rst_stall", {31'd0, stall_f}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, stall_f}, 32'd0);
    chk("mid_rst_flush", {31'd0, flush_f}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt_f}, 32'd0);
    chk("mid_rst_cause", {30'd0, cause_f}, 32'd0);
    chk("mid_rst_r5", rd_f[63:32], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stall_f}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
